// File: rtl/video_timing_if.sv
// Raster timing bundle between the timing generator and the game core.
//   ce          pixel clock-enable, one clk cycle wide
//   hofs/vofs   signed sync offsets (-8..+7), latched by the generator once per frame
//   flip        mirror the reported position on both axes, latched once per frame
//   core_rgb    pixel colour returned by the core for the current hpos/vpos
//   hpos/vpos   position presented to the core (combinational)
//   rgb         blanked colour output
//   hblk/vblk   blanking, active high
//   hsyn/vsyn   sync, active low
//   fstart      one-clk pulse at the start of each frame
// The master modport is the generator's view; slave is the core/driver view.
interface video_timing_if #(
  parameter int unsigned PW = 9,
  parameter int unsigned CW = 12
);
  logic          ce;
  logic [3:0]    hofs;
  logic [3:0]    vofs;
  logic          flip;
  logic [CW-1:0] core_rgb;
  logic [PW-1:0] hpos;
  logic [PW-1:0] vpos;
  logic [CW-1:0] rgb;
  logic          hblk;
  logic          vblk;
  logic          hsyn;
  logic          vsyn;
  logic          fstart;

  modport master (
    input  ce, hofs, vofs, flip, core_rgb,
    output hpos, vpos, rgb, hblk, vblk, hsyn, vsyn, fstart
  );

  modport slave (
    output ce, hofs, vofs, flip, core_rgb,
    input  hpos, vpos, rgb, hblk, vblk, hsyn, vsyn, fstart
  );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator running on the system clock with a pixel
// clock-enable. Produces position, blanking, sync and a blanked colour path, with
// per-frame centering offsets and flip.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   vt     timing bundle (master side), see video_timing_if
module video_timing_gen #(
  parameter int unsigned HACT = 288,
  parameter int unsigned HFP  = 20,
  parameter int unsigned HSW  = 32,
  parameter int unsigned HBP  = 44,
  parameter int unsigned VACT = 224,
  parameter int unsigned VFP  = 11,
  parameter int unsigned VSW  = 7,
  parameter int unsigned VBP  = 22,
  parameter int unsigned PW   = 9,
  parameter int unsigned CW   = 12
) (
  input logic           clk,
  input logic           rst_n,
  video_timing_if.master vt
);

  localparam int unsigned HTOTAL = HACT + HFP + HSW + HBP;
  localparam int unsigned VTOTAL = VACT + VFP + VSW + VBP;

  localparam logic [PW-1:0] HLAST   = PW'(HTOTAL - 1);
  localparam logic [PW-1:0] VLAST   = PW'(VTOTAL - 1);
  localparam logic [PW-1:0] HACT_P  = PW'(HACT);
  localparam logic [PW-1:0] VACT_P  = PW'(VACT);
  localparam logic [PW-1:0] HACT_M1 = PW'(HACT - 1);
  localparam logic [PW-1:0] VACT_M1 = PW'(VACT - 1);

  logic [PW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [3:0]    hofs_q, vofs_q;
  logic          flip_q;
  logic          hblk_q, vblk_q, hsyn_q, vsyn_q, fstart_q;
  logic [CW-1:0] rgb_q;

  logic h_wrap, v_wrap, frame_wrap, h_act, v_act;
  logic signed [PW:0] hcnt_s, vcnt_s, hs0, hs1, vs0, vs1;
  logic in_hs, in_vs;

  always_comb begin
    h_wrap     = (hcnt_q == HLAST);
    v_wrap     = (vcnt_q == VLAST);
    frame_wrap = h_wrap && v_wrap;

    hcnt_d = h_wrap ? '0 : hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (h_wrap) begin
      vcnt_d = v_wrap ? '0 : vcnt_q + 1'b1;
    end

    h_act = (hcnt_q < HACT_P);
    v_act = (vcnt_q < VACT_P);

    // Sync windows in PW+1-bit signed arithmetic so negative offsets subtract cleanly.
    hcnt_s = $signed({1'b0, hcnt_q});
    vcnt_s = $signed({1'b0, vcnt_q});
    hs0    = $signed((PW+1)'(HACT + HFP)) + $signed({{(PW-3){hofs_q[3]}}, hofs_q});
    vs0    = $signed((PW+1)'(VACT + VFP)) + $signed({{(PW-3){vofs_q[3]}}, vofs_q});
    hs1    = hs0 + $signed((PW+1)'(HSW));
    vs1    = vs0 + $signed((PW+1)'(VSW));
    in_hs  = (hcnt_s >= hs0) && (hcnt_s < hs1);
    in_vs  = (vcnt_s >= vs0) && (vcnt_s < vs1);
  end

  // Position is mirrored only inside the active picture; blanking reports raw counts.
  always_comb begin
    vt.hpos = hcnt_q;
    vt.vpos = vcnt_q;
    if (flip_q && h_act && v_act) begin
      vt.hpos = HACT_M1 - hcnt_q;
      vt.vpos = VACT_M1 - vcnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      hofs_q   <= '0;
      vofs_q   <= '0;
      flip_q   <= 1'b0;
      hblk_q   <= 1'b1;
      vblk_q   <= 1'b1;
      hsyn_q   <= 1'b1;
      vsyn_q   <= 1'b1;
      rgb_q    <= '0;
      fstart_q <= 1'b0;
    end else begin
      fstart_q <= 1'b0;
      if (vt.ce) begin
        hcnt_q <= hcnt_d;
        vcnt_q <= vcnt_d;
        // Outputs follow the pre-increment counters: one CE behind hpos/vpos.
        hblk_q <= !h_act;
        vblk_q <= !v_act;
        hsyn_q <= !in_hs;
        if (hcnt_q == '0) begin
          vsyn_q <= !in_vs;
        end
        rgb_q <= (h_act && v_act) ? vt.core_rgb : '0;
        if (frame_wrap) begin
          hofs_q   <= vt.hofs;
          vofs_q   <= vt.vofs;
          flip_q   <= vt.flip;
          fstart_q <= 1'b1;
        end
      end
    end
  end

  assign vt.hblk   = hblk_q;
  assign vt.vblk   = vblk_q;
  assign vt.hsyn   = hsyn_q;
  assign vt.vsyn   = vsyn_q;
  assign vt.rgb    = rgb_q;
  assign vt.fstart = fstart_q;

endmodule
